fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequencer for the instruction-fetch stage.
- Drives the PC register's write enable and the 4-way next-PC select: 0 = PC+4, 1 = {PC+4[31:28], offset28}, 2 = beq target, 3 = jr target.
- Runs the instruction-memory req/ack handshake; applies redirects from ID/EX, load-use stalls and halt; generates IF/ID and ID/EX flush/write controls.

Parameters:
BOOT_CYCLES, 2, idle cycles after reset release before first imem request (1..15)
CNT_W, 32, width of stall counter (optional feature only)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset
imem_ack  in  1  imem returns instruction for current PC this cycle
load_use_stall  in  1  hazard unit: hold PC and IF/ID, bubble ID/EX
branch_taken  in  1  beq resolved taken in EX
jr_id  in  1  jr decoded in ID
jump_id  in  1  j/jal decoded in ID
halt  in  1  stop fetching
imem_req  out  1  fetch request for current PC
pc_write  out  1  PC register enable
pc_src  out  2  next-PC select
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID clear to nop
idex_flush  out  1  ID/EX clear to bubble
halted  out  1  fetch stopped

Behaviour:
- reset low (any time, async): state BOOT, boot counter 0, squash 0.
  - Outputs: imem_req=0, pc_write=0, pc_src=0, ifid_write=0, ifid_flush=1, idex_flush=0, halted=0.
  - An outstanding imem request is abandoned.
- Outputs are Mealy: combinational from state, squash and this cycle's inputs. They take effect at the next rising edge, so the PC updates the cycle after the triggering input.
- BOOT: counts BOOT_CYCLES cycles with all outputs at reset values except ifid_flush=0, then goes to FETCH.
- FETCH:
  - imem_req=1 continuously; each imem_ack cycle completes one fetch.
  - Priority, highest first:
    1. branch_taken: pc_write=1, pc_src=2, ifid_flush=1, idex_flush=1. Overrides load_use_stall, jr_id and jump_id.
    2. load_use_stall: pc_write=0, ifid_write=0, idex_flush=1. jr_id/jump_id are ignored this cycle and re-presented when the stall clears. An ack this cycle is discarded; the same PC is refetched.
    3. jr_id: pc_write=1, pc_src=3, ifid_flush=1.
    4. jump_id: pc_write=1, pc_src=1, ifid_flush=1.
    5. No redirect, no stall:
       - imem_ack and squash=0: pc_write=1, pc_src=0, ifid_write=1.
       - imem_ack and squash=1: discard (ifid_write=0, pc_write=0), clear squash.
       - no ack: all enables 0.
- Squash rules:
  - A redirect in a cycle without imem_ack sets squash=1; the in-flight fetch is wrong-path.
  - A redirect in the same cycle as imem_ack completes that fetch and discards it; squash is unchanged.
  - A redirect while squash=1 keeps squash=1.
- halt (sampled in FETCH, any priority):
  - If a fetch is outstanding and no ack this cycle: go to DRAIN.
  - Otherwise: go to HALT.
  - A redirect in the halt cycle is still applied.
- DRAIN: imem_req=1 until imem_ack, which is discarded (pc_write=0), then HALT.
- HALT: imem_req=0, pc_write=0, ifid_write=0, halted=1. Exit only via reset.
- ifid_write and ifid_flush are never both 1. When a flush applies, ifid_write=0.

Optional Feature:
- FETCH_ctrl is not the macro name; the macro is STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles [CNT_W-1:0].
  - Increments each FETCH/DRAIN cycle with pc_write=0; saturates at all-ones.
  - Cleared by reset.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset low, BOOT_CYCLES=2, release, imem_ack tied 1 → imem_req rises on cycle 3 after release; then pc_write=1, pc_src=0, ifid_write=1 every cycle.
- imem_ack every 3rd cycle → pc_write/ifid_write high only on ack cycles; stall_cycles=2 per fetch with STALL_CNT_EN.
- branch_taken and load_use_stall together → pc_src=2, pc_write=1, ifid_flush=1, idex_flush=1, ifid_write=0.
- jump_id with ack=0, next ack two cycles later → pc_src=1 in redirect cycle; following ack discarded (ifid_write=0); next ack loads IF/ID.
- load_use_stall plus jr_id for 2 cycles, then jr_id alone → pc_write=0, idex_flush=1 for 2 cycles; then pc_src=3, pc_write=1.
- halt with fetch outstanding, ack 2 cycles later → DRAIN, ack discarded, halted=1 next cycle; reset low mid-DRAIN returns all outputs to reset values immediately.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC enable/select, imem req/ack, redirects, stalls, halt.
// Optional STALL_CNT_EN adds a saturating stall_cycles counter output.
module fetch_ctrl #(
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             imem_ack,
    input  logic             load_use_stall,
    input  logic             branch_taken,
    input  logic             jr_id,
    input  logic             jump_id,
    input  logic             halt,
    output logic             imem_req,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
`ifdef STALL_CNT_EN
    output logic [CNT_W-1:0] stall_cycles,
`endif
    output logic             halted
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [1:0] SRC_SEQ  = 2'd0;
    localparam logic [1:0] SRC_JUMP = 2'd1;
    localparam logic [1:0] SRC_BEQ  = 2'd2;
    localparam logic [1:0] SRC_JR   = 2'd3;

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    if (BOOT_CYCLES < 1 || BOOT_CYCLES > 15 || CNT_W < 1) begin : g_bad_param
        $error("fetch_ctrl: BOOT_CYCLES must be 1..15 and CNT_W >= 1");
    end

    logic [1:0] r_state;
    logic [3:0] r_boot_cnt;
    logic       r_squash;
    logic       w_redirect;

    // A stalled jr/j is not a redirect yet; only a taken branch beats the stall.
    assign w_redirect = (r_state == ST_FETCH) &&
                        (branch_taken || (!load_use_stall && (jr_id || jump_id)));

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        imem_req   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = SRC_SEQ;
        ifid_write = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        halted     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    pc_write   = 1'b1;
                    pc_src     = SRC_BEQ;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use_stall) begin
                    idex_flush = 1'b1;
                end else if (jr_id) begin
                    pc_write   = 1'b1;
                    pc_src     = SRC_JR;
                    ifid_flush = 1'b1;
                end else if (jump_id) begin
                    pc_write   = 1'b1;
                    pc_src     = SRC_JUMP;
                    ifid_flush = 1'b1;
                end else if (imem_ack && !r_squash) begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                end
            end
            ST_DRAIN: imem_req = 1'b1;
            ST_HALT:  halted   = 1'b1;
            default:  ;
        endcase
        // IF/ID holds a nop while reset is asserted.
        if (!reset) ifid_flush = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_BOOT;
            r_boot_cnt <= 4'd0;
            r_squash   <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    if (r_boot_cnt == BOOT_LAST) r_state <= ST_FETCH;
                    else                         r_boot_cnt <= r_boot_cnt + 4'd1;
                end
                ST_FETCH: begin
                    // A redirect without the ack leaves a wrong-path fetch in flight.
                    if (w_redirect) begin
                        if (!imem_ack) r_squash <= 1'b1;
                    end else if (!load_use_stall && imem_ack) begin
                        r_squash <= 1'b0;
                    end
                    if (halt) r_state <= imem_ack ? ST_HALT : ST_DRAIN;
                end
                ST_DRAIN: if (imem_ack) r_state <= ST_HALT;
                default:  ;
            endcase
        end
    end

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if ((r_state == ST_FETCH || r_state == ST_DRAIN) && !pc_write &&
                     r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: constant vector table, directed sequences, random vs model.
module tb_fetch_ctrl;

    localparam int BOOT_CYCLES = 2;
    localparam int CNT_W       = 32;

    logic clk = 1'b0;
    logic reset;
    logic imem_ack, load_use_stall, branch_taken, jr_id, jump_id, halt;
    logic imem_req, pc_write, ifid_write, ifid_flush, idex_flush, halted;
    logic [1:0] pc_src;
`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] stall_cycles;
`endif

    fetch_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_ack       (imem_ack),
        .load_use_stall (load_use_stall),
        .branch_taken   (branch_taken),
        .jr_id          (jr_id),
        .jump_id        (jump_id),
        .halt           (halt),
        .imem_req       (imem_req),
        .pc_write       (pc_write),
        .pc_src         (pc_src),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
`ifdef STALL_CNT_EN
        .stall_cycles   (stall_cycles),
`endif
        .halted         (halted)
    );

    always #5 clk = ~clk;

    // Output bundle: {req, pc_write, pc_src[1:0], ifid_write, ifid_flush, idex_flush, halted}
    logic [7:0] w_out;
    assign w_out = {imem_req, pc_write, pc_src, ifid_write, ifid_flush, idex_flush, halted};

    localparam logic [7:0] RESET_OUT = 8'b0000_0100;

    // Input bundle: {stall, branch, jr, jump, ack, halt}
    typedef struct {
        string      name;
        logic [5:0] in;
        logic [7:0] exp;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: what the fetch stage is doing, in plain terms.
    int      m_boot_left;
    bit      m_draining, m_stopped, m_wrong_path;
    longint  m_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_out(input logic [5:0] in);
        logic stall, br, jr, jmp, ack;
        logic pw, iw, ff, xf;
        logic [1:0] src;
        {stall, br, jr, jmp, ack} = in[5:1];
        pw = 0; iw = 0; ff = 0; xf = 0; src = 2'd0;
        if (m_stopped)      return 8'b0000_0001;
        if (m_boot_left > 0) return 8'b0000_0000;
        if (m_draining)     return 8'b1000_0000;
        if (br)             begin pw = 1; src = 2'd2; ff = 1; xf = 1; end
        else if (stall)     xf = 1;
        else if (jr)        begin pw = 1; src = 2'd3; ff = 1; end
        else if (jmp)       begin pw = 1; src = 2'd1; ff = 1; end
        else if (ack && !m_wrong_path) begin pw = 1; iw = 1; end
        return {1'b1, pw, src, iw, ff, xf, 1'b0};
    endfunction

    task automatic model_clock(input logic [5:0] in, input logic [7:0] exp);
        logic stall, br, jr, jmp, ack, hlt;
        bit redirect;
        {stall, br, jr, jmp, ack, hlt} = in;
        if (m_stopped) return;
        if (m_boot_left > 0) begin
            m_boot_left--;
            return;
        end
        if (!exp[6]) m_stall++;
        if (m_draining) begin
            if (ack) begin m_draining = 0; m_stopped = 1; end
            return;
        end
        redirect = br || (!stall && (jr || jmp));
        if (redirect && !ack) m_wrong_path = 1;
        else if (!redirect && !stall && ack) m_wrong_path = 0;
        if (hlt) begin
            if (ack) m_stopped = 1;
            else     m_draining = 1;
        end
    endtask

    task automatic model_reset();
        m_boot_left  = BOOT_CYCLES;
        m_draining   = 0;
        m_stopped    = 0;
        m_wrong_path = 0;
        m_stall      = 0;
    endtask

    // Entered and left just after a falling edge.
    task automatic step(input string name, input logic [5:0] in, output logic [7:0] got);
        logic [7:0] exp;
        {load_use_stall, branch_taken, jr_id, jump_id, imem_ack, halt} = in;
        #1;
        exp = model_out(in);
        got = w_out;
        check(name, {24'd0, got}, {24'd0, exp});
`ifdef STALL_CNT_EN
        check({name, "_stallcnt"}, stall_cycles, m_stall[31:0]);
`endif
        @(posedge clk);
        model_clock(in, exp);
        @(negedge clk);
    endtask

    task automatic do_reset();
        {load_use_stall, branch_taken, jr_id, jump_id, imem_ack, halt} = '0;
        reset = 1'b0;
        #1;
        check("reset_outputs", {24'd0, w_out}, {24'd0, RESET_OUT});
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic boot();
        logic [7:0] g;
        do_reset();
        for (int i = 0; i < BOOT_CYCLES; i++) step("boot", 6'b000010, g);
    endtask

    vec_t tbl[8];

    initial begin
        logic [7:0] g;
        logic [5:0] rin;

        tbl[0] = '{"ack_only",       6'b000010, 8'b1100_1000};
        tbl[1] = '{"idle",           6'b000000, 8'b1000_0000};
        tbl[2] = '{"br_stall_ack",   6'b110010, 8'b1110_0110};
        tbl[3] = '{"stall_jr_ack",   6'b101010, 8'b1000_0010};
        tbl[4] = '{"jr_over_jump",   6'b001100, 8'b1111_0100};
        tbl[5] = '{"jump_ack",       6'b000110, 8'b1101_0100};
        tbl[6] = '{"br_over_jr",     6'b011000, 8'b1110_0110};
        tbl[7] = '{"stall_ack",      6'b100010, 8'b1000_0010};

        reset = 1'b0;
        {load_use_stall, branch_taken, jr_id, jump_id, imem_ack, halt} = '0;
        @(negedge clk);

        // Boot timing with ack tied high: request appears on the third cycle.
        do_reset();
        step("boot_c1", 6'b000010, g); check("boot_req_c1", {31'd0, g[7]}, 32'd0);
        step("boot_c2", 6'b000010, g); check("boot_req_c2", {31'd0, g[7]}, 32'd0);
        step("boot_c3", 6'b000010, g); check("boot_req_c3", {31'd0, g[7]}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step("stream", 6'b000010, g);
            check("stream_pw_src_iw", {28'd0, g[6:3]}, 32'h9);
        end

        // Slow memory: ack every third cycle.
        for (int i = 0; i < 9; i++) begin
            step("slow_mem", (i % 3 == 2) ? 6'b000010 : 6'b000000, g);
            check("slow_pw", {31'd0, g[6]}, (i % 3 == 2) ? 32'd1 : 32'd0);
        end

        // Single-cycle priority vectors, each from a clean FETCH.
        foreach (tbl[k]) begin
            boot();
            step(tbl[k].name, tbl[k].in, g);
            check({tbl[k].name, "_tbl"}, {24'd0, g}, {24'd0, tbl[k].exp});
        end

        // Jump without ack: next ack is wrong-path, the one after loads IF/ID.
        boot();
        step("jmp_noack", 6'b000100, g); check("jmp_src", {30'd0, g[5:4]}, 32'd1);
        step("jmp_wait",  6'b000000, g);
        step("jmp_ack1",  6'b000010, g); check("jmp_discard", {31'd0, g[3]}, 32'd0);
        step("jmp_ack2",  6'b000010, g); check("jmp_load",    {31'd0, g[3]}, 32'd1);

        // Load-use stall holds a jr for two cycles.
        boot();
        for (int i = 0; i < 2; i++) begin
            step("stall_jr", 6'b101000, g);
            check("stall_jr_hold", {30'd0, g[6], g[1]}, 32'b01);
        end
        step("jr_alone", 6'b001000, g);
        check("jr_src_pw", {29'd0, g[6:4]}, 32'b111);

        // Halt with fetch outstanding drains, then stops.
        boot();
        step("halt_noack", 6'b000001, g);
        step("drain_wait", 6'b000000, g); check("drain_req", {31'd0, g[7]}, 32'd1);
        step("drain_ack",  6'b000010, g); check("drain_discard", {31'd0, g[6]}, 32'd0);
        step("halted",     6'b000000, g); check("halted_flag", {24'd0, g}, 32'h01);

        // Reset mid-DRAIN forces reset outputs immediately.
        boot();
        step("halt_noack2", 6'b000001, g);
        #2 reset = 1'b0;
        #1 check("reset_mid_drain", {24'd0, w_out}, {24'd0, RESET_OUT});
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if (m_stopped || $urandom_range(399) == 0) do_reset();
            rin = {($urandom_range(4) == 0), ($urandom_range(7) == 0),
                   ($urandom_range(5) == 0), ($urandom_range(5) == 0),
                   ($urandom_range(2) != 0), ($urandom_range(199) == 0)};
            step("random", rin, g);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
